skid_unloader: RTL and testbench
================================

Name: skid_unloader

Overview:
- AXI-Stream header extractor with a registered skid output.
- Diverts the first HEADER words of every packet to a side header port (h_*). Forwards the remaining body words through a two-entry skid register to the master port (m_*).
- Receive-end counterpart of the loader, which injects a word into a stream. This block strips leading words off a stream before it reaches the DDR3 datapath.

Parameters:
- WIDTH, 8, data width of s/h/m tdata.
- HEADER, 1, header words stripped per packet. Must be >= 1; elaboration error otherwise.
- CBITS, $clog2(HEADER+1), header counter width (localparam).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_tvalid  in  1  source word valid
- s_tready  out  1  source ready
- s_tlast  in  1  source end-of-packet
- s_tdata  in  WIDTH  source data
- h_tvalid  out  1  header word valid
- h_tready  in  1  header consumer ready
- h_tlast  out  1  last header word of this packet
- h_tdata  out  WIDTH  header data
- m_tvalid  out  1  body word valid
- m_tready  in  1  body consumer ready
- m_tlast  out  1  body end-of-packet
- m_tdata  out  WIDTH  body data

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Asserting reset clears state to ST_HEAD, hcnt=0, s_tready=0, h_tvalid=0, m_tvalid=0 and both skid entries invalid. tdata/tlast registers are not reset and are don't-care while their valid is low.
- Post-reset ready: the skid ready register rises on the first clock edge after reset deasserts.
- Transfer rule: a transfer occurs when tvalid && tready on a port at a rising edge.
- FSM ST_HEAD: s_tready = !h_tvalid || h_tready. This is combinational from the header register, so a drained header register accepts back-to-back words.
  - On a transfer, s_tdata loads into the h register and h_tvalid is set next cycle.
  - h_tlast = s_tlast || (hcnt == HEADER-1).
  - hcnt increments.
  - If s_tlast (short packet): hcnt resets to 0, stay in ST_HEAD, nothing emitted on m.
  - Else if hcnt == HEADER-1: hcnt resets to 0, go to ST_BODY.
- FSM ST_BODY: s_tready = registered skid ready, computed as m_tready || !(temp_valid || (m_tvalid && s_tvalid)).
  - Words go to the m output register when it is empty or draining; otherwise they go to the temp register.
  - Temp drains to output when m_tready is high.
  - Full throughput, 1-cycle latency s->m, no bubbles under continuous m_tready.
  - On accepting s_tlast, go to ST_HEAD.
- Ordering across packets: ST_HEAD for packet N+1 may accept header words while packet N body words are still in the skid. h and m ordering is independent across ports but preserved within each port.
- h register backpressure: h holds its word until h_tready, so a stalled header consumer stalls s in ST_HEAD only.
- m register backpressure: m_tvalid/m_tdata/m_tlast are stable while m_tvalid && !m_tready. The same holds for h_*.
- Simultaneous load and drain: h loads and drains in the same cycle allowed. Skid output drains while temp refills allowed.
- Reset mid-packet: partial packet discarded. After reset, the next accepted word is treated as header word 0.

Optional Feature:
- Macro: SKID_UNLOADER_BYPASS_EN.
- With the macro defined: adds input port strip_en (1 bit), sampled on the first word of each packet (ST_HEAD, hcnt==0).
  - If strip_en is low, the whole packet, including what would be header words, is forwarded to m via the skid. The FSM enters ST_BODY directly and h is untouched.
  - strip_en changes mid-packet are ignored.
- Without the macro: no strip_en port; every packet is stripped.

Decomposition:
- Shared package axis_pkg holds:
  - FSM state encoding localparams (ST_HEAD=1'b0, ST_BODY=1'b1).
  - Skid control functions src_ready/tmp_valid/dst_valid. These are shared with the loader so both ends use identical handshake equations.
- One natural sub-module, skid_core: the two-entry registered skid with s/m ports. It is instantiated for the body path, with the FSM gating its s_tvalid.

Test Plan:
- HEADER=1, packet A0,A1,A2 (last on A2), h_tready=m_tready=1 -> h gets A0 with h_tlast=1. m gets A1,A2 one cycle after each input, m_tlast on A2, no bubbles.
- HEADER=2, single-word packet B0 with s_tlast -> h gets B0 with h_tlast=1, m_tvalid stays 0, next packet C0,C1,C2 -> h gets C0 (h_tlast=0), C1 (h_tlast=1), m gets C2 only.
- Body backpressure: m_tready=0 for 3 cycles during body -> at most 2 words held (output+temp), s_tready low next cycle, m_tdata stable, no loss or duplication after release.
- Header stall: h_tready=0 while the next packet's header arrives and the previous body is draining -> body completes on m, s stalls on header word, releases on h_tready=1.
- Async reset asserted mid-body with m_tvalid=1 -> m_tvalid, h_tvalid, s_tready = 0 immediately. After release, the first word goes to h.
- SKID_UNLOADER_BYPASS_EN, strip_en=0 on packet D0,D1 -> m gets D0,D1 with m_tlast on D1, h_tvalid never asserted.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers for the loader/unloader pair: FSM state encoding
// and the two-entry skid handshake equations, so both stream ends use the
// identical ready/valid behaviour.
package axis_pkg;

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    // Early source ready: accept next cycle unless the skid would overflow.
    function automatic logic src_ready(
        input logic dst_ready,
        input logic tmp_v,
        input logic dst_v,
        input logic src_v
    );
        return dst_ready || !(tmp_v || (dst_v && src_v));
    endfunction

    // Next valid of the output entry.
    function automatic logic dst_valid(
        input logic src_rdy_q,
        input logic src_v,
        input logic dst_ready,
        input logic dst_v,
        input logic tmp_v
    );
        logic v;
        v = dst_v;
        if (src_rdy_q) begin
            if (dst_ready || !dst_v) begin
                v = src_v;
            end
        end else if (dst_ready) begin
            v = tmp_v;
        end
        return v;
    endfunction

    // Next valid of the temp entry; it only fills while the output is held.
    function automatic logic tmp_valid(
        input logic src_rdy_q,
        input logic src_v,
        input logic dst_ready,
        input logic dst_v,
        input logic tmp_v
    );
        logic v;
        v = tmp_v;
        if (src_rdy_q) begin
            if (!(dst_ready || !dst_v)) begin
                v = src_v;
            end
        end else if (dst_ready) begin
            v = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/skid_core.sv
// Two-entry registered skid buffer (output entry + temp entry).
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   s_tvalid/s_tready     upstream handshake (s_tready is registered)
//   s_tdata [WIDTH]       upstream payload
//   m_tvalid/m_tready     downstream handshake (m_tvalid is registered)
//   m_tdata [WIDTH]       downstream payload (registered)
module skid_core
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    logic             rdy_q, rdy_d;
    logic             dst_valid_q, dst_valid_d;
    logic             tmp_valid_q, tmp_valid_d;
    logic [WIDTH-1:0] dst_data_q, dst_data_d;
    logic [WIDTH-1:0] tmp_data_q, tmp_data_d;

    // Next-state for handshake flags and payload steering.
    always_comb begin
        rdy_d       = src_ready(m_tready, tmp_valid_q, dst_valid_q, s_tvalid);
        dst_valid_d = dst_valid(rdy_q, s_tvalid, m_tready, dst_valid_q, tmp_valid_q);
        tmp_valid_d = tmp_valid(rdy_q, s_tvalid, m_tready, dst_valid_q, tmp_valid_q);
        dst_data_d  = dst_data_q;
        tmp_data_d  = tmp_data_q;
        if (rdy_q) begin
            // Input goes to output when it is empty or draining, else parks in temp.
            if (m_tready || !dst_valid_q) begin
                dst_data_d = s_tdata;
            end else begin
                tmp_data_d = s_tdata;
            end
        end else if (m_tready) begin
            dst_data_d = tmp_data_q;
        end
    end

    // Control flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q       <= 1'b0;
            dst_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            dst_valid_q <= dst_valid_d;
            tmp_valid_q <= tmp_valid_d;
        end
    end

    // Payload flops; contents are don't-care while the matching valid is low.
    always_ff @(posedge clock) begin
        dst_data_q <= dst_data_d;
        tmp_data_q <= tmp_data_d;
    end

    assign s_tready = rdy_q;
    assign m_tvalid = dst_valid_q;
    assign m_tdata  = dst_data_q;

endmodule

// File: rtl/skid_unloader.sv
// AXI-Stream header extractor: the first HEADER words of each packet go to the
// h_* port through a single register, the rest go to m_* through a two-entry
// skid. Optional macro SKID_UNLOADER_BYPASS_EN adds strip_en, sampled on the
// first word of a packet; when low the whole packet is forwarded to m_*.
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   strip_en                           (bypass build only) strip this packet
//   s_tvalid/s_tready/s_tlast/s_tdata  input stream
//   h_tvalid/h_tready/h_tlast/h_tdata  header words, h_tlast marks the last one
//   m_tvalid/m_tready/m_tlast/m_tdata  body stream
module skid_unloader
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEADER = 1
) (
    input  logic             clock,
    input  logic             reset,
`ifdef SKID_UNLOADER_BYPASS_EN
    input  logic             strip_en,
`endif
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             h_tvalid,
    input  logic             h_tready,
    output logic             h_tlast,
    output logic [WIDTH-1:0] h_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int unsigned CBITS = $clog2(HEADER + 1);

    if (HEADER == 0) begin : g_header_check
        $error("skid_unloader: HEADER must be >= 1");
    end

    state_e           state_q, state_d;
    logic [CBITS-1:0] hcnt_q, hcnt_d;
    logic             run_q;
    logic             h_tvalid_q, h_tvalid_d;
    logic             h_tlast_q, h_tlast_d;
    logic [WIDTH-1:0] h_tdata_q, h_tdata_d;

    logic             bypass_c;
    logic             body_sel_c;
    logic             hdr_ready_c;
    logic             hdr_xfer_c;
    logic             body_xfer_c;
    logic             hdr_end_c;
    logic             core_s_tvalid;
    logic             core_s_tready;
    logic [WIDTH:0]   core_m_data;

`ifdef SKID_UNLOADER_BYPASS_EN
    // Only the first word of a packet may opt out of stripping.
    assign bypass_c = (state_q == ST_HEAD) && (hcnt_q == '0) && !strip_en;
`else
    assign bypass_c = 1'b0;
`endif

    // Current source word is routed into the body skid.
    assign body_sel_c  = (state_q == ST_BODY) || bypass_c;
    // run_q keeps s_tready low through reset and until the first clock edge.
    assign hdr_ready_c = run_q && (!h_tvalid_q || h_tready);
    assign s_tready    = body_sel_c ? core_s_tready : hdr_ready_c;

    assign core_s_tvalid = s_tvalid && body_sel_c;
    assign hdr_xfer_c    = s_tvalid && hdr_ready_c && !body_sel_c;
    assign body_xfer_c   = s_tvalid && core_s_tready && body_sel_c;
    assign hdr_end_c     = (hcnt_q == CBITS'(HEADER - 1));

    // Header register and packet-phase next state.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        h_tvalid_d = h_tvalid_q;
        h_tlast_d  = h_tlast_q;
        h_tdata_d  = h_tdata_q;

        if (h_tvalid_q && h_tready) begin
            h_tvalid_d = 1'b0;
        end

        if (hdr_xfer_c) begin
            h_tvalid_d = 1'b1;
            h_tdata_d  = s_tdata;
            h_tlast_d  = s_tlast || hdr_end_c;
            if (s_tlast || hdr_end_c) begin
                hcnt_d = '0;
                // A short packet ends inside the header and never reaches m.
                if (!s_tlast) begin
                    state_d = ST_BODY;
                end
            end else begin
                hcnt_d = hcnt_q + CBITS'(1);
            end
        end

        if (body_xfer_c) begin
            state_d = s_tlast ? ST_HEAD : ST_BODY;
        end
    end

    // Control flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HEAD;
            hcnt_q     <= '0;
            run_q      <= 1'b0;
            h_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            run_q      <= 1'b1;
            h_tvalid_q <= h_tvalid_d;
        end
    end

    // Header payload; don't-care while h_tvalid is low.
    always_ff @(posedge clock) begin
        h_tlast_q <= h_tlast_d;
        h_tdata_q <= h_tdata_d;
    end

    assign h_tvalid = h_tvalid_q;
    assign h_tlast  = h_tlast_q;
    assign h_tdata  = h_tdata_q;

    skid_core #(
        .WIDTH(WIDTH + 1)
    ) u_body (
        .clock   (clock),
        .reset   (reset),
        .s_tvalid(core_s_tvalid),
        .s_tready(core_s_tready),
        .s_tdata ({s_tlast, s_tdata}),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (core_m_data)
    );

    assign m_tlast = core_m_data[WIDTH];
    assign m_tdata = core_m_data[WIDTH-1:0];

endmodule

// File: tb/tb_skid_unloader.sv
// Self-checking bench for skid_unloader (HEADER=2). Source packets are queued,
// a packet-level model splits each accepted word into expected header/body
// queues, and DUT outputs are compared against those queues every cycle.
module tb_skid_unloader;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HEADER = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             strip;
        logic             first;
    } src_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             strip_en;
    logic             s_tvalid, s_tready, s_tlast;
    logic [WIDTH-1:0] s_tdata;
    logic             h_tvalid, h_tready, h_tlast;
    logic [WIDTH-1:0] h_tdata;
    logic             m_tvalid, m_tready, m_tlast;
    logic [WIDTH-1:0] m_tdata;

    always #5 clock = ~clock;

    skid_unloader #(
        .WIDTH (WIDTH),
        .HEADER(HEADER)
    ) dut (
        .clock   (clock),
        .reset   (reset),
`ifdef SKID_UNLOADER_BYPASS_EN
        .strip_en(strip_en),
`endif
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast (s_tlast),
        .s_tdata (s_tdata),
        .h_tvalid(h_tvalid),
        .h_tready(h_tready),
        .h_tlast (h_tlast),
        .h_tdata (h_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast),
        .m_tdata (m_tdata)
    );

    int          checks = 0;
    int          errors = 0;
    src_t        src_q[$];
    exp_t        hq[$];
    exp_t        mq[$];
    int unsigned widx = 0;
    logic        pkt_strip = 1'b1;
    int unsigned p_sval = 100;
    int unsigned p_hrdy = 100;
    int unsigned p_mrdy = 100;
    bit          full_rate = 1'b0;
    int          hpops = 0;
    int          mpops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_packet(input int unsigned len, input logic strip);
        src_t w;
        for (int unsigned i = 0; i < len; i++) begin
            w.data  = WIDTH'($urandom);
            w.last  = (i == len - 1);
            w.strip = strip;
            w.first = (i == 0);
            src_q.push_back(w);
        end
    endtask

    // Reference split: the first HEADER words of a stripped packet are header.
    task automatic model_accept(input logic [WIDTH-1:0] d, input logic l, input logic strip);
        exp_t e;
        if (widx == 0) pkt_strip = strip;
        e.data = d;
        if (pkt_strip && widx < HEADER) begin
            e.last = l || (widx == HEADER - 1);
            hq.push_back(e);
        end else begin
            e.last = l;
            mq.push_back(e);
        end
        widx = l ? 0 : widx + 1;
    endtask

    task automatic tick();
        bit   sa, ha, ma;
        logic strip_s;
        @(negedge clock);
        if (!s_tvalid && src_q.size() != 0 && $urandom_range(99) < p_sval) begin
            s_tvalid = 1'b1;
            s_tdata  = src_q[0].data;
            s_tlast  = src_q[0].last;
        end
`ifdef SKID_UNLOADER_BYPASS_EN
        if (s_tvalid) strip_en = src_q[0].first ? src_q[0].strip : 1'($urandom_range(1));
        strip_s = strip_en;
`else
        strip_s = 1'b1;
`endif
        h_tready = ($urandom_range(99) < p_hrdy);
        m_tready = ($urandom_range(99) < p_mrdy);
        #1;
        sa = s_tvalid && s_tready;
        ha = h_tvalid && h_tready;
        ma = m_tvalid && m_tready;
        chk("h_valid", 32'(h_tvalid), 32'(hq.size() != 0));
        chk("m_valid", 32'(m_tvalid), 32'(mq.size() != 0));
        if (h_tvalid && hq.size() != 0) begin
            chk("h_tdata", 32'(h_tdata), 32'(hq[0].data));
            chk("h_tlast", 32'(h_tlast), 32'(hq[0].last));
        end
        if (m_tvalid && mq.size() != 0) begin
            chk("m_tdata", 32'(m_tdata), 32'(mq[0].data));
            chk("m_tlast", 32'(m_tlast), 32'(mq[0].last));
        end
        if (full_rate) chk("s_tready_full_rate", 32'(s_tready), 32'd1);
        if (ha && hq.size() != 0) begin void'(hq.pop_front()); hpops++; end
        if (ma && mq.size() != 0) begin void'(mq.pop_front()); mpops++; end
        if (sa) begin
            model_accept(s_tdata, s_tlast, strip_s);
            void'(src_q.pop_front());
        end
        @(posedge clock);
        #1;
        if (sa) s_tvalid = 1'b0;
    endtask

    task automatic drain(input int max_ticks);
        int n = 0;
        while ((src_q.size() != 0 || s_tvalid || hq.size() != 0 || mq.size() != 0) && n < max_ticks) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(src_q.size() + hq.size() + mq.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        h_tready = 1'b0;
        m_tready = 1'b0;
        strip_en = 1'b1;

        // Reset state and post-reset ready timing.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_h_tvalid", 32'(h_tvalid), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("s_tready_pre_edge", 32'(s_tready), 32'd0);
        @(posedge clock);
        #1;
        chk("s_tready_post_edge", 32'(s_tready), 32'd1);

        // Full rate: normal, short and longer packets with no bubbles.
        p_sval = 100; p_hrdy = 100; p_mrdy = 100;
        full_rate = 1'b1;
        hpops = 0; mpops = 0;
        gen_packet(3, 1'b1);
        gen_packet(1, 1'b1);
        gen_packet(3, 1'b1);
        gen_packet(5, 1'b1);
        drain(100);
        full_rate = 1'b0;
        chk("dir_h_words", 32'(hpops), 32'd7);
        chk("dir_m_words", 32'(mpops), 32'd5);

        // Body backpressure: skid holds two words, then source stalls.
        p_mrdy = 0;
        mpops = 0;
        gen_packet(8, 1'b1);
        repeat (7) tick();
        chk("bp_s_stalled", 32'(s_tready), 32'd0);
        chk("bp_m_held", 32'(m_tvalid), 32'd1);
        chk("bp_two_in_skid", 32'(mq.size()), 32'd2);
        p_mrdy = 100;
        drain(100);
        chk("bp_m_words", 32'(mpops), 32'd6);

        // Header stall while previous body is still draining.
        p_hrdy = 100; p_mrdy = 0;
        gen_packet(4, 1'b1);
        gen_packet(3, 1'b1);
        n = 0;
        while (src_q.size() > 3 && n < 30) begin tick(); n++; end
        chk("hs_first_pkt_in", 32'(src_q.size()), 32'd3);
        p_hrdy = 0; p_mrdy = 100;
        repeat (6) tick();
        chk("hs_body_done", 32'(m_tvalid), 32'd0);
        chk("hs_h_held", 32'(h_tvalid), 32'd1);
        chk("hs_s_stalled", 32'(s_tready), 32'd0);
        p_hrdy = 100;
        drain(100);

`ifdef SKID_UNLOADER_BYPASS_EN
        // Unstripped packet goes entirely to m.
        full_rate = 1'b1;
        hpops = 0; mpops = 0;
        gen_packet(2, 1'b0);
        drain(50);
        full_rate = 1'b0;
        chk("byp_h_words", 32'(hpops), 32'd0);
        chk("byp_m_words", 32'(mpops), 32'd2);
`endif

        // Randomized traffic and backpressure.
        for (int k = 0; k < 30; k++) begin
`ifdef SKID_UNLOADER_BYPASS_EN
            gen_packet(1 + $urandom_range(4), 1'($urandom_range(1)));
`else
            gen_packet(1 + $urandom_range(4), 1'b1);
`endif
        end
        for (int k = 0; k < 600; k++) begin
            if (k % 40 == 0) begin
                p_sval = $urandom_range(100, 30);
                p_hrdy = $urandom_range(100, 20);
                p_mrdy = $urandom_range(100, 20);
            end
            tick();
        end
        p_sval = 100; p_hrdy = 100; p_mrdy = 100;
        drain(300);

        // Asynchronous reset in the middle of a body.
        p_mrdy = 0;
        gen_packet(6, 1'b1);
        n = 0;
        while (!m_tvalid && n < 20) begin tick(); n++; end
        chk("mid_body_m_valid", 32'(m_tvalid), 32'd1);
        tick();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_h_tvalid", 32'(h_tvalid), 32'd0);
        chk("arst_s_tready", 32'(s_tready), 32'd0);
        s_tvalid = 1'b0;
        src_q.delete();
        hq.delete();
        mq.delete();
        widx = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        p_mrdy = 100;
        hpops = 0; mpops = 0;
        gen_packet(3, 1'b1);
        drain(100);
        chk("post_rst_h_words", 32'(hpops), 32'(HEADER));
        chk("post_rst_m_words", 32'(mpops), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
